// File: rtl/cpu_mem_req_ctrl_if.sv
// Bundles the per-port pipeline demand, private bus channels and status outputs
// of the CPU memory request controller.
interface cpu_mem_req_ctrl_if #(
  parameter int unsigned NPORT     = 2,
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned DATA_BITS = 32
);
  logic [NPORT-1:0]           pipe_rd_i;
  logic [NPORT-1:0]           pipe_wr_i;
  logic [NPORT*ADDR_BITS-1:0] pipe_addr_i;
  logic [NPORT*DATA_BITS-1:0] pipe_wdata_i;
  logic [NPORT*4-1:0]         pipe_web_i;
  logic [NPORT-1:0]           bus_req_o;
  logic [NPORT-1:0]           bus_read_o;
  logic [NPORT-1:0]           bus_write_o;
  logic [NPORT*ADDR_BITS-1:0] bus_addr_o;
  logic [NPORT*DATA_BITS-1:0] bus_wdata_o;
  logic [NPORT*4-1:0]         bus_web_o;
  logic [NPORT-1:0]           bus_wait_i;
  logic [NPORT*DATA_BITS-1:0] bus_rdata_i;
  logic [NPORT*DATA_BITS-1:0] rdata_o;
  logic                       stall_o;
  logic [NPORT-1:0]           timeout_o;

  modport master (
    input  pipe_rd_i, pipe_wr_i, pipe_addr_i, pipe_wdata_i, pipe_web_i, bus_wait_i, bus_rdata_i,
    output bus_req_o, bus_read_o, bus_write_o, bus_addr_o, bus_wdata_o, bus_web_o, rdata_o,
           stall_o, timeout_o
  );

  modport slave (
    output pipe_rd_i, pipe_wr_i, pipe_addr_i, pipe_wdata_i, pipe_web_i, bus_wait_i, bus_rdata_i,
    input  bus_req_o, bus_read_o, bus_write_o, bus_addr_o, bus_wdata_o, bus_web_o, rdata_o,
           stall_o, timeout_o
  );
endinterface

// File: rtl/cpu_mem_req_ctrl.sv
// Per-port CPU memory request FSMs (IDLE/REQ/BUSY/DONE) with per-port timeout and a
// global pipeline stall; ports leave DONE together once no port is still in flight.
module cpu_mem_req_ctrl #(
  parameter int unsigned NPORT     = 2,
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned TO_CYC    = 255
) (
  input  logic               clk,
  input  logic               rst,
  cpu_mem_req_ctrl_if.master bus_if
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StBusy = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [7:0] ToLimit = 8'(TO_CYC);

  logic [1:0]           state_q [NPORT];
  logic [1:0]           state_d [NPORT];
  logic [7:0]           cnt_q   [NPORT];
  logic [7:0]           cnt_d   [NPORT];
  logic [ADDR_BITS-1:0] addr_q  [NPORT];
  logic [ADDR_BITS-1:0] addr_d  [NPORT];
  logic [DATA_BITS-1:0] wdata_q [NPORT];
  logic [DATA_BITS-1:0] wdata_d [NPORT];
  logic [DATA_BITS-1:0] rdata_q [NPORT];
  logic [DATA_BITS-1:0] rdata_d [NPORT];
  logic [3:0]           web_q   [NPORT];
  logic [3:0]           web_d   [NPORT];
  logic [NPORT-1:0]     wr_q, wr_d;
  logic [NPORT-1:0]     to_q, to_d;
  logic [NPORT-1:0]     active;
  logic [NPORT-1:0]     demand;
  logic [NPORT-1:0]     idle_dem;
  logic                 any_active;

  always_comb begin
    active   = '0;
    demand   = '0;
    idle_dem = '0;
    for (int p = 0; p < NPORT; p++) begin
      active[p]   = (state_q[p] == StReq) || (state_q[p] == StBusy);
      demand[p]   = bus_if.pipe_rd_i[p] | bus_if.pipe_wr_i[p];
      idle_dem[p] = (state_q[p] == StIdle) && demand[p];
    end
    any_active = |active;
  end

  always_comb begin
    wr_d = wr_q;
    to_d = to_q;
    for (int p = 0; p < NPORT; p++) begin
      state_d[p] = state_q[p];
      cnt_d[p]   = cnt_q[p];
      addr_d[p]  = addr_q[p];
      wdata_d[p] = wdata_q[p];
      web_d[p]   = web_q[p];
      rdata_d[p] = rdata_q[p];
      unique case (state_q[p])
        StIdle: begin
          if (demand[p]) begin
            state_d[p] = StReq;
            cnt_d[p]   = '0;
            wr_d[p]    = bus_if.pipe_wr_i[p];
            addr_d[p]  = bus_if.pipe_addr_i[p*ADDR_BITS +: ADDR_BITS];
            wdata_d[p] = bus_if.pipe_wdata_i[p*DATA_BITS +: DATA_BITS];
            web_d[p]   = bus_if.pipe_web_i[p*4 +: 4];
          end
        end
        StReq: begin
          if (cnt_q[p] == ToLimit) begin
            state_d[p] = StDone;
            to_d[p]    = 1'b1;
            if (!wr_q[p]) rdata_d[p] = '0;
          end else begin
            cnt_d[p] = cnt_q[p] + 8'd1;
            if (bus_if.bus_wait_i[p]) state_d[p] = StBusy;
          end
        end
        StBusy: begin
          // Completion is checked first so it wins over a coincident timeout.
          if (!bus_if.bus_wait_i[p]) begin
            state_d[p] = StDone;
            if (!wr_q[p]) rdata_d[p] = bus_if.bus_rdata_i[p*DATA_BITS +: DATA_BITS];
          end else if (cnt_q[p] == ToLimit) begin
            state_d[p] = StDone;
            to_d[p]    = 1'b1;
            if (!wr_q[p]) rdata_d[p] = '0;
          end else begin
            cnt_d[p] = cnt_q[p] + 8'd1;
          end
        end
        StDone: begin
          if (!any_active) state_d[p] = StIdle;
        end
        default: state_d[p] = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      to_q <= '0;
      for (int p = 0; p < NPORT; p++) begin
        state_q[p] <= StIdle;
        cnt_q[p]   <= '0;
        addr_q[p]  <= '0;
        wdata_q[p] <= '0;
        web_q[p]   <= '0;
        rdata_q[p] <= '0;
      end
    end else begin
      wr_q <= wr_d;
      to_q <= to_d;
      for (int p = 0; p < NPORT; p++) begin
        state_q[p] <= state_d[p];
        cnt_q[p]   <= cnt_d[p];
        addr_q[p]  <= addr_d[p];
        wdata_q[p] <= wdata_d[p];
        web_q[p]   <= web_d[p];
        rdata_q[p] <= rdata_d[p];
      end
    end
  end

  // Bus fields are only driven while a port is in flight, so IDLE/DONE/reset read as zero.
  always_comb begin
    bus_if.bus_req_o   = '0;
    bus_if.bus_read_o  = '0;
    bus_if.bus_write_o = '0;
    bus_if.bus_addr_o  = '0;
    bus_if.bus_wdata_o = '0;
    bus_if.bus_web_o   = '0;
    bus_if.rdata_o     = '0;
    for (int p = 0; p < NPORT; p++) begin
      bus_if.bus_req_o[p]   = (state_q[p] == StReq);
      bus_if.bus_read_o[p]  = active[p] & ~wr_q[p];
      bus_if.bus_write_o[p] = active[p] & wr_q[p];
      bus_if.rdata_o[p*DATA_BITS +: DATA_BITS] = rdata_q[p];
      if (active[p]) begin
        bus_if.bus_addr_o[p*ADDR_BITS +: ADDR_BITS]  = addr_q[p];
        bus_if.bus_wdata_o[p*DATA_BITS +: DATA_BITS] = wdata_q[p];
        bus_if.bus_web_o[p*4 +: 4]                   = web_q[p];
      end
    end
    bus_if.stall_o   = |(active | idle_dem);
    bus_if.timeout_o = to_q;
  end

endmodule
